alu_arbiter: RTL

- Sequencing controller that shares the single 4-bit `ALU` datapath between two independent requesters.
- Arbitrates incoming operation requests and registers the operands and opcode.
- Drives the `ALU` for one execute cycle, then packs the selected result into one 5-bit response held under a valid/ready handshake.
- Sits between the two requesting blocks and the `ALU` instance, which it owns internally.

---
 rtl/alu_arbiter_pkg.sv | 22 ++
 rtl/ALU.sv | 50 +++++
 rtl/rr_arb2.sv | 45 ++++
 rtl/alu_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
//   Shared definitions for the ALU arbiter slice. It holds the opcode
//   encodings, the FSM state encodings and the packed response width.
//   alu_arbiter and its sub-modules import it.
package alu_arbiter_pkg;

  localparam int RESP_W = 5;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_CMP = 2'd2,
    OP_AND = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/ALU.sv
// ALU
//   A 4-bit combinational ALU with a separate output group for each
//   operation. Only the group chosen by S is driven with a result; every
//   other group reads zero.
// Ports:
//   A, B      in  4  operands
//   S         in  2  select: 0 add, 1 sub, 2 compare, 3 and
//   SumAdd    out 4  / CarryAdd out 1   : A + B
//   SumSub    out 4  / CarrySub out 1   : A - B, carry = 1 when A >= B
//   Greater, Equal, Less out 1          : magnitude compare
//   OutAnd    out 4                     : A & B
module ALU (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [1:0] S,
  output logic [3:0] SumAdd,
  output logic       CarryAdd,
  output logic [3:0] SumSub,
  output logic       CarrySub,
  output logic       Greater,
  output logic       Equal,
  output logic       Less,
  output logic [3:0] OutAnd
);

  always_comb begin
    SumAdd   = 4'd0;
    CarryAdd = 1'b0;
    SumSub   = 4'd0;
    CarrySub = 1'b0;
    Greater  = 1'b0;
    Equal    = 1'b0;
    Less     = 1'b0;
    OutAnd   = 4'd0;
    case (S)
      2'd0: {CarryAdd, SumAdd} = {1'b0, A} + {1'b0, B};
      2'd1: begin
        SumSub   = A - B;
        CarrySub = (A >= B);      // no borrow
      end
      2'd2: begin
        Greater = (A > B);
        Equal   = (A == B);
        Less    = (A < B);
      end
      default: OutAnd = A & B;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2
//   Combinational two-way grant with a one-bit priority pointer.
//   RR = 1: on contention the pointer wins, then it moves to the loser.
//   RR = 0: on contention requester 0 always wins; the pointer never moves.
// Ports:
//   clk, rst_n   in   clock, asynchronous active-low reset
//   valids       in 2 request valids, bit N = requester N
//   advance      in   the grant is being consumed this cycle
//   grant_valid  out  some requester is granted
//   grant_id     out  which requester is granted
module rr_arb2 #(
  parameter int RR = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valids,
  input  logic       advance,
  output logic       grant_valid,
  output logic       grant_id
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    grant_valid = |valids;
    if (valids == 2'b11) begin
      grant_id = (RR != 0) ? prio_q : 1'b0;
    end else begin
      grant_id = valids[1];
    end

    prio_d = prio_q;
    // The pointer only moves when both requesters actually competed.
    if ((RR != 0) && advance && (valids == 2'b11)) begin
      prio_d = ~grant_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one 4-bit ALU between two requesters. IDLE grants a request and
//   latches its operands; EXEC drives the ALU for one cycle and captures the
//   packed 5-bit result; RESP holds the result until resp_ready.
//   Optional feature macro: ALU_ARB_CNT_EN adds op_count[7:0], the number of
//   completed responses (wraps at 255).
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b        requester N handshake and payload
//   resp_valid/ready/id/data       response handshake, owner id, packed result
//   op_count (ALU_ARB_CNT_EN only) completed response count
//   busy                           FSM is not in IDLE
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int RR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [3:0]        req0_a,
  input  logic [3:0]        req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [3:0]        req1_a,
  input  logic [3:0]        req1_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [RESP_W-1:0] resp_data,
`ifdef ALU_ARB_CNT_EN
  output logic [7:0]        op_count,
`endif
  output logic              busy
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [3:0]        a_q, a_d, b_q, b_d;
  logic              id_q, id_d;
  logic [RESP_W-1:0] resp_data_q, resp_data_d;
  logic [RESP_W-1:0] alu_packed;

  logic grant_valid, grant_id, in_idle;

  logic [3:0] sum_add, sum_sub, out_and;
  logic       carry_add, carry_sub, greater, equal, less;

  assign in_idle = (state_q == ST_IDLE);

  rr_arb2 #(.RR(RR)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .valids      ({req1_valid, req0_valid}),
    .advance     (in_idle),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  ALU u_alu (
    .A        (a_q),
    .B        (b_q),
    .S        (op_q),
    .SumAdd   (sum_add),
    .CarryAdd (carry_add),
    .SumSub   (sum_sub),
    .CarrySub (carry_sub),
    .Greater  (greater),
    .Equal    (equal),
    .Less     (less),
    .OutAnd   (out_and)
  );

  // Pick the output group that belongs to the latched opcode.
  always_comb begin
    case (op_q)
      OP_ADD:  alu_packed = {carry_add, sum_add};
      OP_SUB:  alu_packed = {carry_sub, sum_sub};
      OP_CMP:  alu_packed = {2'b00, greater, equal, less};
      default: alu_packed = {1'b0, out_and};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    resp_data_d = resp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d = ST_EXEC;
          id_d    = grant_id;
          op_d    = grant_id ? op_e'(req1_op) : op_e'(req0_op);
          a_d     = grant_id ? req1_a : req0_a;
          b_d     = grant_id ? req1_b : req0_b;
        end
      end
      ST_EXEC: begin
        resp_data_d = alu_packed;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      id_q        <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Ready is a pure function of the valids and the state; it never feeds back.
  assign req0_ready = in_idle && grant_valid && !grant_id;
  assign req1_ready = in_idle && grant_valid &&  grant_id;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_id    = id_q;
  assign resp_data  = resp_data_q;
  assign busy       = !in_idle;

`ifdef ALU_ARB_CNT_EN
  logic [7:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if ((state_q == ST_RESP) && resp_ready) op_count_d = op_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count_q <= 8'd0;
    else        op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif

endmodule
